// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

    // Controller state: free-running or inside a multi-cycle load-use stall.
    typedef enum logic [0:0] {
        RUN      = 1'b0,
        LD_STALL = 1'b1
    } ctrlState_t;

    // Architectural zero register; writes to it are discarded, so it never creates a dependency.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Largest legal number of bubbles per load-use hazard (the down-counter is 2 bits).
    localparam int LOAD_USE_MAX = 3;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the controller's performance statistics.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    // Count up on request, sticking at all-ones instead of wrapping.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush generator for the PC, IF/ID, ID/RR, RR/EX and EX/MEM latches.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int LOAD_USE_CYCLES = 1,
    parameter int CNT_W           = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_uses_rs2_i,
    input  logic             rr_memread_i,
    input  logic [4:0]       rr_rd_i,
    input  logic             ex_branch_taken_i,
    input  logic             ex_jump_i,
    input  logic             mem_busy_i,
    output logic             pc_lock_o,
    output logic             if_id_lock_o,
    output logic             id_rr_lock_o,
    output logic             rr_ex_lock_o,
    output logic             ex_mem_lock_o,
    output logic             if_id_flush_o,
    output logic             id_rr_flush_o,
    output logic             rr_ex_flush_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    // The bubble count must fit the 2-bit down-counter and be at least one.
    if (LOAD_USE_CYCLES < 1 || LOAD_USE_CYCLES > LOAD_USE_MAX) begin : g_badLoadUseCycles
        $error("pipe_hazard_ctrl: LOAD_USE_CYCLES must be in 1..%0d", LOAD_USE_MAX);
    end

    // Value loaded into rem when a hazard starts a multi-cycle stall.
    localparam logic [1:0] REM_INIT = 2'(LOAD_USE_CYCLES - 1);

    ctrlState_t r_state;
    ctrlState_t w_nextState;
    logic [1:0] r_rem;
    logic [1:0] w_nextRem;
    logic       w_hazard;
    logic       w_redirect;
    logic       w_stallInc;
    logic       w_flushInc;

    // A load in RR feeding a source operand of the instruction in ID; x0 and unread rs2 never match.
    assign w_hazard = rr_memread_i && (rr_rd_i != REG_ZERO) &&
                      ((rr_rd_i == id_rs1_i) || (id_uses_rs2_i && (rr_rd_i == id_rs2_i)));

    assign w_redirect = ex_branch_taken_i || ex_jump_i;

    // Priority chain reset > freeze > redirect > stall continuation / new hazard > normal.
    always_comb begin
        pc_lock_o     = 1'b0;
        if_id_lock_o  = 1'b0;
        id_rr_lock_o  = 1'b0;
        rr_ex_lock_o  = 1'b0;
        ex_mem_lock_o = 1'b0;
        if_id_flush_o = 1'b0;
        id_rr_flush_o = 1'b0;
        rr_ex_flush_o = 1'b0;
        w_stallInc    = 1'b0;
        w_flushInc    = 1'b0;
        w_nextState   = r_state;
        w_nextRem     = r_rem;

        if (rst_i) begin
            w_nextState = RUN;
            w_nextRem   = 2'd0;
        end else if (mem_busy_i) begin
            // Whole pipe holds; any pending stall resumes once memory is ready.
            pc_lock_o     = 1'b1;
            if_id_lock_o  = 1'b1;
            id_rr_lock_o  = 1'b1;
            rr_ex_lock_o  = 1'b1;
            ex_mem_lock_o = 1'b1;
            w_stallInc    = 1'b1;
        end else if (w_redirect) begin
            // Squash the three younger slots; PC is free to load the target.
            if_id_flush_o = 1'b1;
            id_rr_flush_o = 1'b1;
            rr_ex_flush_o = 1'b1;
            w_flushInc    = 1'b1;
            w_nextState   = RUN;
            w_nextRem     = 2'd0;
        end else if (r_state == LD_STALL) begin
            // RR already holds a bubble, so hazard inputs are not looked at here.
            pc_lock_o     = 1'b1;
            if_id_lock_o  = 1'b1;
            id_rr_flush_o = 1'b1;
            w_stallInc    = 1'b1;
            w_nextRem     = r_rem - 2'd1;
            if (r_rem == 2'd1) begin
                w_nextState = RUN;
            end
        end else if (w_hazard) begin
            pc_lock_o     = 1'b1;
            if_id_lock_o  = 1'b1;
            id_rr_flush_o = 1'b1;
            w_stallInc    = 1'b1;
            if (LOAD_USE_CYCLES > 1) begin
                w_nextState = LD_STALL;
                w_nextRem   = REM_INIT;
            end
        end
    end

    // State and remaining-bubble register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= RUN;
            r_rem   <= 2'd0;
        end else begin
            r_state <= w_nextState;
            r_rem   <= w_nextRem;
        end
    end

    sat_counter #(.W(CNT_W)) u_stallCounter (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_inc   (w_stallInc),
        .o_count (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flushCounter (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_inc   (w_flushInc),
        .o_count (flush_cnt_o)
    );

endmodule
